// File: rtl/sync_pkg.sv
// Shared constants and helpers for the sync_filter_edge synchronizer/filter slice.
package sync_pkg;

  localparam int GLITCH_CNT_W = 16;

  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;
  localparam int FILT_MIN   = 1;
  localparam int FILT_MAX   = 255;

  // Filter counter width; a single bit even when no filtering is requested.
  function automatic int cnt_w(input int filt);
    int w;
    w = $clog2(filt);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: flop-chain synchronizer, stability filter, registered level and edge pulses,
// plus a combinational strobe marking the cycle a partial run is abandoned.
module sync_filter_ch
  import sync_pkg::*;
#(
  parameter int   STAGES   = 2,
  parameter int   FILT_CNT = 4,
  parameter logic RST_BIT  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data_i,
  output logic data_o,
  output logic rise_o,
  output logic fall_o,
  output logic glitch_o
);

  localparam int               CNT_W    = cnt_w(FILT_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

  logic [STAGES-1:0] r_sync;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_data;
  logic              r_rise;
  logic              r_fall;
  logic              w_s;

  assign w_s      = r_sync[STAGES-1];
  assign data_o   = r_data;
  assign rise_o   = r_rise;
  assign fall_o   = r_fall;
  // A nonzero count being dropped without a flip is exactly a rejected glitch.
  assign glitch_o = (w_s == r_data) && (r_cnt != '0);

  // NOTE: every register here uses <= so all stages sample the pre-edge values;
  // blocking assignments would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_BIT}};
      r_cnt  <= '0;
      r_data <= RST_BIT;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], data_i};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_data) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_data <= w_s;
        r_rise <= w_s;
        r_fall <= ~w_s;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sync_filter_edge.sv
// N_CH-channel synchronizer with per-channel glitch filter and edge pulses.
// Optional saturating rejected-glitch counter enabled by `define SYNC_GLITCH_STAT_EN.
module sync_filter_edge
  import sync_pkg::*;
#(
  parameter int              N_CH     = 4,
  parameter int              STAGES   = 2,
  parameter int              FILT_CNT = 4,
  parameter logic [N_CH-1:0] RST_VAL  = {N_CH{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         data_i,
  output logic [N_CH-1:0]         data_o,
  output logic [N_CH-1:0]         rise_o,
  output logic [N_CH-1:0]         fall_o
`ifdef SYNC_GLITCH_STAT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt_o,
  input  logic                    glitch_clr_i
`endif
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("sync_filter_edge: STAGES must be within 2..4");
  end
  if (FILT_CNT < FILT_MIN || FILT_CNT > FILT_MAX) begin : g_bad_filt
    $error("sync_filter_edge: FILT_CNT must be within 1..255");
  end

`ifdef SYNC_GLITCH_STAT_EN
  logic [N_CH-1:0] w_glitch;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    sync_filter_ch #(
      .STAGES   (STAGES),
      .FILT_CNT (FILT_CNT),
      .RST_BIT  (RST_VAL[g])
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_i   (data_i[g]),
      .data_o   (data_o[g]),
      .rise_o   (rise_o[g]),
      .fall_o   (fall_o[g]),
`ifdef SYNC_GLITCH_STAT_EN
      .glitch_o (w_glitch[g])
`else
      .glitch_o ()
`endif
    );
  end

`ifdef SYNC_GLITCH_STAT_EN
  logic [GLITCH_CNT_W:0]   w_glitch_sum;
  logic [GLITCH_CNT_W-1:0] r_glitch_cnt;

  // NOTE: the sum gets a default before the loop so the block stays purely combinational.
  always_comb begin
    w_glitch_sum = {1'b0, r_glitch_cnt};
    for (int i = 0; i < N_CH; i++) begin
      w_glitch_sum = w_glitch_sum + (GLITCH_CNT_W + 1)'(w_glitch[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_glitch_cnt <= '0;
    end else if (glitch_clr_i) begin
      r_glitch_cnt <= '0;
    end else if (w_glitch_sum[GLITCH_CNT_W]) begin
      r_glitch_cnt <= '1;
    end else begin
      r_glitch_cnt <= w_glitch_sum[GLITCH_CNT_W-1:0];
    end
  end

  assign glitch_cnt_o = r_glitch_cnt;
`endif

endmodule

// File: tb/tb_sync_filter_edge.sv
// Self-checking bench: default instance (STAGES=2, FILT_CNT=4) and a fast one (STAGES=3,
// FILT_CNT=1), both compared every cycle against a sample-window reference model.
module tb_sync_filter_edge;

  logic       clk;
  logic       rst_n;
  logic [3:0] din_a, din_b;
  logic [3:0] dout_a, rise_a, fall_a;
  logic [3:0] dout_b, rise_b, fall_b;
  logic       glitch_clr;
`ifdef SYNC_GLITCH_STAT_EN
  logic [15:0] gcnt_a, gcnt_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  sync_filter_edge #(.N_CH(4), .STAGES(2), .FILT_CNT(4)) u_dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_i       (din_a),
    .data_o       (dout_a),
    .rise_o       (rise_a),
    .fall_o       (fall_a)
`ifdef SYNC_GLITCH_STAT_EN
    ,
    .glitch_cnt_o (gcnt_a),
    .glitch_clr_i (glitch_clr)
`endif
  );

  sync_filter_edge #(.N_CH(4), .STAGES(3), .FILT_CNT(1)) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_i       (din_b),
    .data_o       (dout_b),
    .rise_o       (rise_b),
    .fall_o       (fall_b)
`ifdef SYNC_GLITCH_STAT_EN
    ,
    .glitch_cnt_o (gcnt_b),
    .glitch_clr_i (glitch_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the filter flips a bit once its last FLT synchronized samples all
  // disagree with the current level; a sample agreeing right after a disagreeing one
  // abandons a partial run (a glitch). Synchronized sample at edge k = data_i at edge k-STG.
  int         STG [2] = '{2, 3};
  int         FLT [2] = '{4, 1};
  logic [3:0] m_hist [2][16];
  logic [3:0] m_dout [2];
  logic [3:0] m_rise [2];
  logic [3:0] m_fall [2];
  int         m_gcnt [2];

  task automatic m_reset();
    for (int m = 0; m < 2; m++) begin
      for (int j = 0; j < 16; j++) m_hist[m][j] = 4'h0;
      m_dout[m] = 4'h0;
      m_rise[m] = 4'h0;
      m_fall[m] = 4'h0;
      m_gcnt[m] = 0;
    end
  endtask

  task automatic m_step(input int m, input logic [3:0] din, input logic clr);
    int ng;
    bit run;
    for (int j = 15; j > 0; j--) m_hist[m][j] = m_hist[m][j-1];
    m_hist[m][0] = din;
    m_rise[m] = 4'h0;
    m_fall[m] = 4'h0;
    ng = 0;
    for (int c = 0; c < 4; c++) begin
      run = 1'b1;
      for (int j = 0; j < FLT[m]; j++)
        if (m_hist[m][STG[m]+j][c] == m_dout[m][c]) run = 1'b0;
      if (run) begin
        m_dout[m][c] = ~m_dout[m][c];
        if (m_dout[m][c]) m_rise[m][c] = 1'b1;
        else              m_fall[m][c] = 1'b1;
      end else if (m_hist[m][STG[m]][c] == m_dout[m][c] &&
                   m_hist[m][STG[m]+1][c] != m_dout[m][c]) begin
        ng++;
      end
    end
    if (clr) m_gcnt[m] = 0;
    else     m_gcnt[m] = (m_gcnt[m] + ng > 65535) ? 65535 : m_gcnt[m] + ng;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else begin
      m_step(0, din_a, glitch_clr);
      m_step(1, din_b, glitch_clr);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("a_data", dout_a, m_dout[0]);
      check("a_rise", rise_a, m_rise[0]);
      check("a_fall", fall_a, m_fall[0]);
      check("b_data", dout_b, m_dout[1]);
      check("b_rise", rise_b, m_rise[1]);
      check("b_fall", fall_b, m_fall[1]);
      check("a_rise_and_fall", rise_a & fall_a, 4'h0);
`ifdef SYNC_GLITCH_STAT_EN
      check("a_gcnt", gcnt_a, m_gcnt[0]);
      check("b_gcnt", gcnt_b, m_gcnt[1]);
`endif
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [3:0] acc;
    rst_n = 1'b0;
    din_a = 4'h0;
    din_b = 4'h0;
    glitch_clr = 1'b0;
    m_reset();
    @(posedge clk);
    cmp_en = 1'b1;
    cycles(2);
    rst_n = 1'b1;

    // Reset state and idle: no pulses over 20 cycles.
    acc = 4'h0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      acc = acc | rise_a | fall_a;
    end
    check("idle_pulses", acc, 4'h0);
    check("idle_data", dout_a, 4'h0);

    // Channel 0 rises: data_o[0] and rise_o[0] appear after edge 6 only.
    @(negedge clk);
    din_a = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      if (e == 5) check("ch0_edge5_data", dout_a, 4'b0000);
      if (e == 6) begin
        check("ch0_edge6_data", dout_a, 4'b0001);
        check("ch0_edge6_rise", rise_a, 4'b0001);
      end
      if (e == 7) begin
        check("ch0_edge7_rise", rise_a, 4'b0000);
        check("ch0_edge7_data", dout_a, 4'b0001);
      end
    end

    // Channel 1 high for exactly 3 cycles: rejected.
    @(negedge clk);
    din_a = 4'b0011;
    cycles(3);
    din_a = 4'b0001;
    cycles(10);
    check("ch1_glitch_data", dout_a, 4'b0001);
`ifdef SYNC_GLITCH_STAT_EN
    check("ch1_glitch_cnt", gcnt_a, 16'd1);
`endif

    // All channels low, then all rise together.
    din_a = 4'h0;
    cycles(8);
    din_a = 4'hF;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (e == 5) check("all_edge5_data", dout_a, 4'h0);
      if (e == 6) check("all_edge6_rise", rise_a, 4'hF);
    end

    // All channels glitch low for 2 cycles: +4 glitches in one cycle.
    @(negedge clk);
    din_a = 4'h0;
    cycles(2);
    din_a = 4'hF;
    cycles(8);
    check("all_glitch_data", dout_a, 4'hF);
`ifdef SYNC_GLITCH_STAT_EN
    check("all_glitch_cnt", gcnt_a, 16'd5);
`endif

    // Another glitch with clear on the very edge it is counted: clear wins.
    din_a = 4'h0;
    cycles(2);
    din_a = 4'hF;
    cycles(2);
    glitch_clr = 1'b1;
    @(posedge clk); #1;
`ifdef SYNC_GLITCH_STAT_EN
    check("clr_priority", gcnt_a, 16'd0);
`endif
    check("clr_glitch_data", dout_a, 4'hF);
    @(negedge clk);
    glitch_clr = 1'b0;

    // Fast instance: toggling every 2 cycles, 4-cycle latency, alternating pulses.
    din_b = 4'b0001;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (e == 3) check("b_edge3_data", dout_b, 4'b0000);
      if (e == 4) begin
        check("b_edge4_data", dout_b, 4'b0001);
        check("b_edge4_rise", rise_b, 4'b0001);
      end
      if (e == 6) begin
        check("b_edge6_data", dout_b, 4'b0000);
        check("b_edge6_fall", fall_b, 4'b0001);
      end
      @(negedge clk);
      if (e % 2 == 0) din_b[0] = ~din_b[0];
    end

    // Reset while channel counters sit at 2, then no pulse before a full interval.
    din_a = 4'h0;
    cycles(4);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_data", dout_a, 4'h0);
    check("async_rst_pulse", rise_a | fall_a, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    din_a = 4'hF;
    acc = 4'h0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      if (e <= 5) acc = acc | rise_a | fall_a;
      if (e == 6) check("post_rst_rise", rise_a, 4'hF);
    end
    check("post_rst_quiet", acc, 4'h0);

    // Randomized traffic with occasional clears and one mid-run reset.
    @(negedge clk);
    for (int k = 0; k < 400; k++) begin
      din_a = din_a ^ (4'($urandom) & 4'($urandom));
      din_b = din_b ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      glitch_clr = ($urandom_range(0, 31) == 0);
      if (k == 200) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
